// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: start/busy/done handshake plus the
// latched operands and registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: STEP bits per clock, LSB first, with the ripple
// carry held in a register between slices. Subtraction is a + ~b + ~cin.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg, b_reg, work_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg, ovf_reg, done_reg;
    logic             accept, finish;

    // Ripple chain for one slice; slice_c[STEP-1] is the carry into the slice MSB.
    logic [STEP:0]          slice_c;
    logic [STEP-1:0]        slice_s;
    logic [WIDTH+STEP-1:0]  work_cat;
    logic [WIDTH-1:0]       work_shift;

    assign slice_c[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_cell
            assign slice_s[gi]   = a_reg[gi] ^ b_reg[gi] ^ slice_c[gi];
            assign slice_c[gi+1] = (a_reg[gi] & b_reg[gi]) |
                                   (slice_c[gi] & (a_reg[gi] ^ b_reg[gi]));
        end
    endgenerate

    // Result bits enter at the top and drift down, so after N slices slice 0 sits at bit 0.
    assign work_cat   = {slice_s, work_reg};
    assign work_shift = work_cat[WIDTH+STEP-1:STEP];

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == LAST) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= finish;
            if (accept) begin
                cnt_reg   <= '0;
                a_reg     <= bus.a;
                b_reg     <= bus.b ^ {WIDTH{bus.sub}};
                carry_reg <= bus.cin ^ bus.sub;
                work_reg  <= '0;
            end else if (state_reg == RUN) begin
                cnt_reg   <= cnt_reg + CW'(1);
                a_reg     <= a_reg >> STEP;
                b_reg     <= b_reg >> STEP;
                carry_reg <= slice_c[STEP];
                work_reg  <= work_shift;
            end
            if (finish) begin
                sum_reg  <= work_shift;
                cout_reg <= slice_c[STEP];
                ovf_reg  <= slice_c[STEP] ^ slice_c[STEP-1];
            end
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a STEP=1 and a STEP=4 instance (WIDTH=8), table vectors,
// handshake/reset sequences and a random sweep, all checked through per-DUT scoreboards.
module tb_serial_adder;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         acc;
        int         n;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nvec = 0;
    int   nmis = 0;
    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(8)) bus1 ();
    serial_adder_if #(.WIDTH(8)) bus4 ();

    serial_adder #(.WIDTH(8), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    serial_adder #(.WIDTH(8), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endfunction

    // Independent reference: 9-bit sum of a, the (possibly inverted) b and the carry.
    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic cin, logic sub);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, cin ^ sub};
        e.s  = full[7:0];
        e.co = full[8];
        e.ov = (a[7] == bb[7]) && (full[7] != a[7]);
        e.acc = 0;
        e.n   = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus1.done) begin
            if (q1.size() == 0) begin
                chk("step1 spurious done", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("step1 sum", bus1.sum, e.s);
                chk("step1 cout", bus1.cout, e.co);
                chk("step1 ovf", bus1.ovf, e.ov);
                chk("step1 latency", cyc - e.acc, e.n + 1);
                chk("step1 busy at done", bus1.busy, 0);
            end
        end
        if (!rst && bus4.done) begin
            if (q4.size() == 0) begin
                chk("step4 spurious done", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("step4 sum", bus4.sum, e.s);
                chk("step4 cout", bus4.cout, e.co);
                chk("step4 ovf", bus4.ovf, e.ov);
                chk("step4 latency", cyc - e.acc, e.n + 1);
            end
        end
    end

    // Caller must be at a negedge; returns at the negedge after the accept edge.
    task automatic go(int sel, logic [7:0] a, logic [7:0] b, logic cin, logic sub,
                      logic [7:0] es, logic eco, logic eov);
        exp_t e;
        e.s   = es;
        e.co  = eco;
        e.ov  = eov;
        e.acc = cyc;
        if (sel == 0) begin
            e.n = 8;
            bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub;
        end else begin
            e.n = 2;
            bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub;
        end
        @(posedge clk);
        if (sel == 0) q1.push_back(e);
        else          q4.push_back(e);
        @(negedge clk);
        bus1.start = 1'b0;
        bus4.start = 1'b0;
        bus1.a = $urandom; bus1.b = $urandom;
        bus4.a = $urandom; bus4.b = $urandom;
    endtask

    task automatic wait_all(int sel);
        for (int i = 0; i < 64; i++) begin
            if (sel == 0 && q1.size() == 0 && !bus1.busy) break;
            if (sel == 1 && q4.size() == 0 && !bus4.busy) break;
            @(negedge clk);
        end
        if (sel == 0) chk("step1 completion timeout", q1.size(), 0);
        else          chk("step4 completion timeout", q4.size(), 0);
    endtask

    vec_t vecs[7];
    exp_t m;

    initial begin
        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h55, 8'h2A, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0};

        rst = 1'b1;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", bus1.busy, 0);
        chk("reset done", bus1.done, 0);
        chk("reset sum", bus1.sum, 0);
        chk("reset cout", bus1.cout, 0);
        chk("reset ovf", bus1.ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        // First vector: busy for exactly 8 sampled cycles, then done.
        go(0, vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, vecs[0].s, vecs[0].co, vecs[0].ov);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("busy during run %0d", i), bus1.busy, 1);
            chk($sformatf("no done during run %0d", i), bus1.done, 0);
            @(negedge clk);
        end
        chk("done after 8 cycles", bus1.done, 1);
        wait_all(0);

        for (int i = 1; i < 7; i++) begin
            go(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].co, vecs[i].ov);
            wait_all(0);
        end

        // start mid-run must be ignored; original operands finish.
        go(0, 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus1.start = 1'b1; bus1.a = 8'hFF; bus1.b = 8'hFF; bus1.cin = 1'b1; bus1.sub = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_all(0);
        repeat (10) @(negedge clk);

        // start together with done: back-to-back, old result holds meanwhile.
        go(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 20 && bus1.done !== 1'b1; i++) @(negedge clk);
        chk("done seen for back-to-back", bus1.done, 1);
        go(0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("first result held %0d", i), bus1.sum, 8'h80);
            @(negedge clk);
        end
        wait_all(0);

        // Asynchronous reset mid-operation.
        go(0, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        wait_all(0);
        go(0, 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", bus1.busy, 0);
        chk("async rst done", bus1.done, 0);
        chk("async rst sum", bus1.sum, 0);
        chk("async rst cout", bus1.cout, 0);
        chk("async rst ovf", bus1.ovf, 0);
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        go(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        wait_all(0);

        // STEP=4 instance: two-cycle latency, then random sweep.
        go(1, 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
        wait_all(1);
        for (int i = 0; i < 600; i++) begin
            logic [7:0] ra, rb;
            logic       rc, rs;
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            m  = model(ra, rb, rc, rs);
            go(1, ra, rb, rc, rs, m.s, m.co, m.ov);
            wait_all(1);
        end
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            logic       rc, rs;
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            m  = model(ra, rb, rc, rs);
            go(0, ra, rb, rc, rs, m.s, m.co, m.ov);
            wait_all(0);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that processes two `WIDTH`-bit operands `STEP` bits per clock, LSB first, carrying the ripple carry in a register between cycles. It extends the single-bit full-adder cell to arbitrary operand widths, adds a subtract mode and signed-overflow detection, and uses a start/busy/done handshake. It sits in arithmetic datapaths where area matters more than latency.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be at least 2.
- `STEP`, 1: bits processed per clock; must satisfy `WIDTH % STEP == 0`.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `start`  in  1  requests an operation; sampled only when `busy` is 0.
- `a`  in  WIDTH  operand A; latched when `start` is accepted.
- `b`  in  WIDTH  operand B; latched when `start` is accepted.
- `cin`  in  1  carry-in (add) or borrow-in (subtract); latched when `start` is accepted.
- `sub`  in  1  mode select: 0 computes `a+b+cin`, 1 computes `a-b-cin`; latched when `start` is accepted.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when the result is valid.
- `sum`  out  WIDTH  result, modulo 2^WIDTH.
- `cout`  out  1  carry-out; in subtract mode, 1 means no borrow.
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- Number of processing cycles: N = WIDTH/STEP.
- Subtract mode is implemented as `a + ~b + ~cin`. On accept, latch B as `b ^ {WIDTH{sub}}` and set the initial carry to `cin ^ sub`.
- FSM states and transitions:
  - IDLE: moves to RUN when `start`=1.
  - RUN: holds a slice counter k = 0..N-1. Each cycle adds operand slice k and the carry register, writes STEP result bits into a working shift register, and updates the carry. After slice N-1 the FSM moves to IDLE.
- On leaving RUN:
  - Copy the working register to `sum`.
  - Set `cout` to the final carry.
  - Set `ovf` to (carry into the MSB) XOR (carry out of the MSB). The carry into the MSB is the internal carry at bit WIDTH-1 within the last slice.
  - Pulse `done`.
- `sum`, `cout` and `ovf` are output registers that change only at completion. They hold their values through IDLE and through any later RUN until the next completion.
- `start` while `busy`=1 is ignored; operands are not re-latched.
- `start`=1 in the same cycle as `done`=1 is accepted, so back-to-back operations are allowed. The previous result stays on the outputs until the new operation completes.
- `a`, `b`, `cin` and `sub` are don't-care except in the accept cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0. The FSM returns to IDLE and the counter, carry and working registers clear.
- Reset takes effect immediately, including mid-operation; the in-flight operation is abandoned with no `done`.
- `start` is accepted at edge E0. `busy`=1 after E0.
- Slices 0..N-1 are processed at edges E1..EN.
- After EN: `busy`=0, `done`=1 for exactly one cycle, and the result is valid.
- Latency from the accept edge to `done` is N cycles. Throughput is one operation per N cycles.
- With STEP = WIDTH (N=1): `done` follows the accept edge by one cycle.

## Test plan
- WIDTH=8, STEP=1, add: `a`=8'h3C, `b`=8'h0F, `cin`=0. Required: `sum`=8'h4B, `cout`=0, `ovf`=0, with `done` exactly 8 cycles after the accept edge and `busy` high for those 8 cycles.
- Carry chain and overflow (WIDTH=8, STEP=1):
  - 8'hFF + 8'h01 with `cin`=1 gives `sum`=8'h01, `cout`=1, `ovf`=0.
  - 8'h7F + 8'h01 with `cin`=0 gives `sum`=8'h80, `cout`=0, `ovf`=1.
- Subtract (WIDTH=8, STEP=1):
  - 8'h10 - 8'h20 with `cin`=0 gives `sum`=8'hF0, `cout`=0, `ovf`=0.
  - 8'h80 - 8'h01 gives `sum`=8'h7F, `cout`=1, `ovf`=1.
- WIDTH=8, STEP=4: 8'h3C + 8'h0F gives 8'h4B with `done` 2 cycles after accept. Sweep all 2^17 combinations of `a`, `b` and `cin` (a random subset for WIDTH=16) against a behavioural model in both modes.
- Handshake:
  - Pulse `start` with new operands mid-RUN: ignored, and the original result is delivered.
  - Assert `start` during `done`: a second operation is accepted, and the first result holds until the second completes.
- Assert `rst` for 1 cycle at slice 3 of an 8-cycle operation: all outputs clear immediately, no `done` pulse follows, and the next `start` operates normally.
